dat_fifo: RTL and testbench

Single-clock, first-word-fall-through (FWFT) data FIFO on the SD DAT path.
- Write direction: the host/DMA side writes 32-bit words; the FIFO drives them to dat_phys on dataFROMFIFO, and dat_phys pops one word per serialized word.
- Read direction: a second instance buffers deserialized words from dat_phys toward the host.
- Provides full/empty, programmable almost thresholds, occupancy count and sticky overflow/underflow error flags.

---
 rtl/dat_fifo_if.sv | 28 ++
 rtl/dat_fifo.sv | 80 ++++++++
 tb/tb_dat_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dat_fifo_if.sv
// rtl/dat_fifo_if.sv - producer/consumer handshake bundle for the DAT-path FIFO
interface dat_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  clear;
  logic                  writeEnable;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  readEnable;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, writeEnable, dataIn, readEnable,
    input  dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, writeEnable, dataIn, readEnable,
    output dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/dat_fifo.sv
// rtl/dat_fifo.sv - single-clock first-word-fall-through FIFO for the SD DAT path
module dat_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input logic        sd_clock,
  input logic        reset,
  dat_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf;
  logic                  unf;
  logic                  is_full;
  logic                  is_empty;
  logic                  push;
  logic                  pop;

  // Flags come only from the occupancy register, so a full wrap never looks empty.
  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);
  assign push     = bus.writeEnable && (!is_full || bus.readEnable);
  assign pop      = bus.readEnable && !is_empty;

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
  assign bus.dataOut      = is_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sd_clock) begin
    if (!reset && !bus.clear && push) begin
      mem[wr_ptr] <= bus.dataIn;
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (ADDR_WIDTH + 1)'(1);
      end else if (pop && !push) begin
        cnt <= cnt - (ADDR_WIDTH + 1)'(1);
      end
      if (bus.writeEnable && is_full && !bus.readEnable) begin
        ovf <= 1'b1;
      end
      if (bus.readEnable && is_empty) begin
        unf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dat_fifo.sv
// tb/tb_dat_fifo.sv - directed self-checking bench for dat_fifo
module tb_dat_fifo;
  logic sd_clock = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  dat_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  dat_fifo #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(14), .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .sd_clock(sd_clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge, outputs are sampled there too.
  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic idle();
    bus.clear       = 1'b0;
    bus.writeEnable = 1'b0;
    bus.readEnable  = 1'b0;
    bus.dataIn      = '0;
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.writeEnable = 1'b1;
    bus.dataIn      = w;
    tick();
    idle();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] w);
    chk(tag, bus.dataOut, w);
    bus.readEnable = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk("rst_dout", bus.dataOut, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);

    for (int i = 1; i <= 16; i++) begin
      push_word(32'(i));
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_afull", 32'(bus.almost_full), (i >= 14) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(bus.full), (i == 16) ? 32'd1 : 32'd0);
    end
    chk("fill_ovf", 32'(bus.overflow), 32'd0);

    for (int i = 1; i <= 16; i++) begin
      pop_expect("drain_data", 32'(i));
      chk("drain_count", 32'(bus.count), 32'(16 - i));
      chk("drain_aempty", 32'(bus.almost_empty), (16 - i <= 2) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_unf", 32'(bus.underflow), 32'd0);

    bus.readEnable = 1'b1;
    tick();
    idle();
    chk("rd_empty_unf", 32'(bus.underflow), 32'd1);
    chk("rd_empty_count", 32'(bus.count), 32'd0);
    chk("rd_empty_dout", bus.dataOut, 32'd0);

    bus.writeEnable = 1'b1;
    bus.readEnable  = 1'b1;
    bus.dataIn      = 32'h55;
    tick();
    idle();
    chk("wr_rd_empty_count", 32'(bus.count), 32'd1);
    chk("wr_rd_empty_dout", bus.dataOut, 32'h55);
    pop_expect("wr_rd_empty_pop", 32'h55);
    chk("wr_rd_empty_drained", 32'(bus.count), 32'd0);

    for (int i = 0; i < 10; i++) push_word(32'h10 + 32'(i));
    for (int i = 0; i < 10; i++) pop_expect("wrap_pre", 32'h10 + 32'(i));
    for (int i = 0; i < 12; i++) push_word(32'hA0 + 32'(i));
    chk("wrap_count", 32'(bus.count), 32'd12);
    for (int i = 0; i < 12; i++) pop_expect("wrap_data", 32'hA0 + 32'(i));
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    chk("full2", 32'(bus.full), 32'd1);
    chk("wr_rd_full_head", bus.dataOut, 32'h100);
    bus.writeEnable = 1'b1;
    bus.readEnable  = 1'b1;
    bus.dataIn      = 32'h200;
    tick();
    idle();
    chk("wr_rd_full_count", 32'(bus.count), 32'd16);
    chk("wr_rd_full_ovf", 32'(bus.overflow), 32'd0);
    chk("wr_rd_full_next", bus.dataOut, 32'h101);

    push_word(32'hDEADBEEF);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_head", bus.dataOut, 32'h101);

    bus.clear = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) push_word(32'h300 + 32'(i));
    chk("pre_clear_count", 32'(bus.count), 32'd5);
    bus.clear       = 1'b1;
    bus.writeEnable = 1'b1;
    bus.dataIn      = 32'h77;
    tick();
    idle();
    chk("clear_count", 32'(bus.count), 32'd0);
    chk("clear_empty", 32'(bus.empty), 32'd1);
    chk("clear_ovf_kept", 32'(bus.overflow), 32'd1);
    chk("clear_unf_kept", 32'(bus.underflow), 32'd1);
    chk("clear_dout", bus.dataOut, 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_ovf", 32'(bus.overflow), 32'd0);
    chk("reset_unf", 32'(bus.underflow), 32'd0);

    push_word(32'd3792842);
    chk("phys_count1", 32'(bus.count), 32'd1);
    pop_expect("phys_data", 32'd3792842);
    chk("phys_count0", 32'(bus.count), 32'd0);
    chk("phys_unf", 32'(bus.underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
